// File: rtl/tetris_pkg.sv
// Shared board geometry, cell addressing, line-clear score table and controller state encoding.
// Pure declarations: no latency, no flow control.
package tetris_pkg;

  localparam int BOARD_COLS   = 10;
  localparam int BOARD_ROWS   = 20;
  localparam int BOARD_CELL_W = 3;

  localparam logic [10:0] SCORE_BASE [0:4] = '{11'd0, 11'd40, 11'd100, 11'd300, 11'd1200};

  typedef enum logic [2:0] {
    LCC_IDLE,
    LCC_SCAN,
    LCC_CLEAR,
    LCC_SETTLE,
    LCC_DONE
  } lcc_state_e;

  // Column-major: a whole column of ROWS cells is contiguous.
  function automatic int cell_idx(input int x, input int y,
                                  input int rows = BOARD_ROWS,
                                  input int cell_w = BOARD_CELL_W);
    return x * rows * cell_w + y * cell_w;
  endfunction

  function automatic logic [10:0] base_points(input logic [2:0] n);
    case (n)
      3'd1:    return SCORE_BASE[1];
      3'd2:    return SCORE_BASE[2];
      3'd3:    return SCORE_BASE[3];
      3'd4:    return SCORE_BASE[4];
      default: return SCORE_BASE[0];
    endcase
  endfunction

endpackage

// File: rtl/row_full_check.sv
// Combinational full-row detector: a row is full when every one of its COLS cells is non-empty.
// Zero latency; no flow control.
module row_full_check
  import tetris_pkg::*;
#(
  parameter int COLS   = BOARD_COLS,
  parameter int ROWS   = BOARD_ROWS,
  parameter int CELL_W = BOARD_CELL_W
) (
  input  logic [COLS*ROWS*CELL_W-1:0] board_arr,
  input  logic [$clog2(ROWS)-1:0]     row_idx,
  output logic                        full
);

  logic [COLS-1:0] cell_nz;

  always_comb begin
    cell_nz = '0;
    for (int x = 0; x < COLS; x++) begin
      cell_nz[x] = |board_arr[cell_idx(x, int'(row_idx), ROWS, CELL_W) +: CELL_W];
    end
  end

  assign full = &cell_nz;

endmodule

// File: rtl/line_clear_ctrl.sv
// Post-lock line-clear controller: scans one row per cycle, pulses CLEAR for full rows, then updates HUD stats.
// DONE in cycle 21 after START (23 when rows clear); START while busy is dropped, no queueing.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int COLS      = BOARD_COLS,
  parameter int ROWS      = BOARD_ROWS,
  parameter int CELL_W    = BOARD_CELL_W,
  parameter int SCORE_W   = 20,
  parameter int LEVEL_MAX = 15
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        START,
  input  logic                        NEW_GAME,
  input  logic [COLS*ROWS*CELL_W-1:0] board_arr,
  output logic [ROWS-1:0]             lines,
  output logic                        CLEAR,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [2:0]                  n_cleared,
  output logic [15:0]                 total_lines,
  output logic [3:0]                  level,
  output logic [SCORE_W-1:0]          score
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);

  lcc_state_e        state_q;
  logic [RW-1:0]     row_idx_q;
  logic [ROWS-1:0]   lines_q;
  logic              clear_q, busy_q, done_q;
  logic [2:0]        n_cleared_q;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic [15:0]        total_q, total_d;
  logic [3:0]         ltn_q, ltn_d;

  logic              row_full;
  logic [ROWS-1:0]   mask_final;
  logic [CW-1:0]     cnt;
  logic [2:0]        n_clamp;

  row_full_check #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W)) u_row_full (
    .board_arr (board_arr),
    .row_idx   (row_idx_q),
    .full      (row_full)
  );

  // Mask including the row being scanned this cycle, so the last row counts toward the decision.
  always_comb begin
    mask_final = lines_q | ({{(ROWS-1){1'b0}}, row_full} << row_idx_q);
    cnt = '0;
    for (int y = 0; y < ROWS; y++) begin
      cnt = cnt + CW'(mask_final[y]);
    end
    n_clamp = (cnt > CW'(4)) ? 3'd4 : cnt[2:0];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= LCC_IDLE;
      row_idx_q   <= '0;
      lines_q     <= '0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      n_cleared_q <= '0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        LCC_IDLE: begin
          if (START) begin
            state_q   <= LCC_SCAN;
            busy_q    <= 1'b1;
            row_idx_q <= '0;
            lines_q   <= '0;
          end
        end
        LCC_SCAN: begin
          lines_q[row_idx_q] <= row_full;
          if (row_idx_q == RW'(ROWS - 1)) begin
            n_cleared_q <= n_clamp;
            if (mask_final != '0) begin
              state_q <= LCC_CLEAR;
              clear_q <= 1'b1;
            end else begin
              state_q <= LCC_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            row_idx_q <= row_idx_q + 1'b1;
          end
        end
        LCC_CLEAR: state_q <= LCC_SETTLE;
        LCC_SETTLE: begin
          state_q <= LCC_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= LCC_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [4:0]         lvl_p1;
  logic [15:0]        prod;
  logic [SCORE_W:0]   score_sum;
  logic [16:0]        total_sum;
  logic [4:0]         ltn_sum;

  // Stats land on the SETTLE->DONE edge; a no-clear pass has n=0 and would change nothing anyway.
  always_comb begin
    lvl_p1    = {1'b0, level_q} + 5'd1;
    prod      = 16'(base_points(n_cleared_q)) * 16'(lvl_p1);
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(prod);
    total_sum = {1'b0, total_q} + 17'(n_cleared_q);
    ltn_sum   = {1'b0, ltn_q} + 5'(n_cleared_q);

    score_d = score_q;
    level_d = level_q;
    total_d = total_q;
    ltn_d   = ltn_q;

    if (NEW_GAME) begin
      score_d = '0;
      level_d = '0;
      total_d = '0;
      ltn_d   = '0;
    end else if (state_q == LCC_SETTLE) begin
      score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
      if (ltn_sum >= 5'd10) begin
        ltn_d   = 4'(ltn_sum - 5'd10);
        level_d = (level_q >= 4'(LEVEL_MAX)) ? level_q : level_q + 4'd1;
      end else begin
        ltn_d = ltn_sum[3:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      score_q <= '0;
      level_q <= '0;
      total_q <= '0;
      ltn_q   <= '0;
    end else begin
      score_q <= score_d;
      level_q <= level_d;
      total_q <= total_d;
      ltn_q   <= ltn_d;
    end
  end

  assign lines       = lines_q;
  assign CLEAR       = clear_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign n_cleared   = n_cleared_q;
  assign total_lines = total_q;
  assign level       = level_q;
  assign score       = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: hand-computed scoring, timing and reset scenarios.
module tb_line_clear_ctrl;

  logic         CLK;
  logic         RESET_N;
  logic         START;
  logic         NEW_GAME;
  logic [599:0] board;
  logic [19:0]  lines;
  logic         CLEAR, BUSY, DONE;
  logic [2:0]   n_cleared;
  logic [15:0]  total_lines;
  logic [3:0]   level;
  logic [19:0]  score;

  int ntests = 0;
  int nfail  = 0;

  int          clr_cyc, done_cyc, n_clr, n_done;
  logic [19:0] score_at_done, lines_c1;
  logic        busy_c1;

  line_clear_ctrl dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .NEW_GAME    (NEW_GAME),
    .board_arr   (board),
    .lines       (lines),
    .CLEAR       (CLEAR),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .n_cleared   (n_cleared),
    .total_lines (total_lines),
    .level       (level),
    .score       (score)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_board(input logic [19:0] full_rows);
    board = '0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        if (full_rows[y]) board[x*60 + y*3 +: 3] = 3'((x + y) % 7 + 1);
  endtask

  // One START; watch 40 cycles. Cycle 1 is the cycle right after the START edge.
  task automatic run_op(input int repulse, input bit ng_at_done);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    clr_cyc = 0; done_cyc = 0; n_clr = 0; n_done = 0; score_at_done = '0;
    lines_c1 = lines; busy_c1 = BUSY;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge CLK);
      START = (c == repulse);
      if (CLEAR) begin
        n_clr++;
        if (clr_cyc == 0) clr_cyc = c;
      end
      if (DONE) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          score_at_done = score;
        end
      end
      NEW_GAME = DONE && ng_at_done;
    end
    START = 1'b0;
    NEW_GAME = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [31:0] e_lines, input int e_clr,
                          input int e_done, input logic [31:0] e_n, input logic [31:0] e_score,
                          input logic [31:0] e_total, input logic [31:0] e_level);
    chk({tag, ".lines"},     32'(lines), e_lines);
    chk({tag, ".clr_cyc"},   32'(clr_cyc), 32'(e_clr));
    chk({tag, ".done_cyc"},  32'(done_cyc), 32'(e_done));
    chk({tag, ".n_done"},    32'(n_done), 32'd1);
    chk({tag, ".n_cleared"}, 32'(n_cleared), e_n);
    chk({tag, ".score"},     32'(score), e_score);
    chk({tag, ".total"},     32'(total_lines), e_total);
    chk({tag, ".level"},     32'(level), e_level);
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; NEW_GAME = 1'b0;
    build_board(20'h0);
    #5;
    chk("rst.lines", 32'(lines), 32'h0);
    chk("rst.flags", 32'({CLEAR, BUSY, DONE}), 32'h0);
    chk("rst.stats", 32'({n_cleared, level, total_lines}), 32'h0);
    chk("rst.score", 32'(score), 32'h0);
    @(negedge CLK); RESET_N = 1'b1;

    // Empty board plus two 9-of-10 rows that must not count as full.
    build_board(20'h0);
    for (int x = 0; x < 9; x++) board[x*60 + 5*3 +: 3] = 3'd7;
    for (int x = 1; x < 10; x++) board[x*60 +: 3] = 3'd2;
    run_op(0, 1'b0);
    check_op("empty", 32'h0, 0, 21, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("empty.busy_c1", 32'(busy_c1), 32'd1);
    chk("empty.busy_end", 32'(BUSY), 32'd0);

    build_board(20'h80000);
    run_op(0, 1'b0);
    check_op("row19", 32'h80000, 21, 23, 32'd1, 32'd40, 32'd1, 32'd0);
    chk("row19.n_clr", 32'(n_clr), 32'd1);

    @(negedge CLK); NEW_GAME = 1'b1;
    @(negedge CLK); NEW_GAME = 1'b0;
    chk("ng_idle.score", 32'(score), 32'd0);
    chk("ng_idle.total", 32'(total_lines), 32'd0);
    chk("ng_idle.lines_kept", 32'(lines), 32'h80000);

    build_board(20'hF0000);
    run_op(0, 1'b0);
    check_op("tetris1", 32'hF0000, 21, 23, 32'd4, 32'd1200, 32'd4, 32'd0);
    chk("tetris1.lines_c1", 32'(lines_c1), 32'h0);
    run_op(0, 1'b0);
    check_op("tetris2", 32'hF0000, 21, 23, 32'd4, 32'd2400, 32'd8, 32'd0);

    build_board(20'hE0000);
    run_op(0, 1'b0);
    check_op("triple_lvlup", 32'hE0000, 21, 23, 32'd3, 32'd2700, 32'd11, 32'd1);

    build_board(20'hF0000);
    run_op(0, 1'b0);
    check_op("l1_t1", 32'hF0000, 21, 23, 32'd4, 32'd5100, 32'd15, 32'd1);
    run_op(0, 1'b0);
    check_op("l1_t2", 32'hF0000, 21, 23, 32'd4, 32'd7500, 32'd19, 32'd1);

    build_board(20'h80000);
    run_op(0, 1'b0);
    check_op("single_lvlup", 32'h80000, 21, 23, 32'd1, 32'd7580, 32'd20, 32'd2);

    build_board(20'hF0000);
    run_op(0, 1'b0);
    check_op("tetris_l2", 32'hF0000, 21, 23, 32'd4, 32'd11180, 32'd24, 32'd2);

    // START re-pulsed mid-scan, NEW_GAME held during the DONE cycle.
    build_board(20'h80000);
    run_op(5, 1'b1);
    chk("repulse.n_done", 32'(n_done), 32'd1);
    chk("repulse.n_clr", 32'(n_clr), 32'd1);
    chk("repulse.done_cyc", 32'(done_cyc), 32'd23);
    chk("repulse.score_at_done", 32'(score_at_done), 32'd11300);
    chk("ng_done.score", 32'(score), 32'd0);
    chk("ng_done.level", 32'(level), 32'd0);
    chk("ng_done.total", 32'(total_lines), 32'd0);

    build_board(20'hF0000);
    for (int i = 1; i <= 74; i++) begin
      run_op(0, 1'b0);
      if (i == 40) begin
        chk("sat40.level", 32'(level), 32'd15);
        chk("sat40.score", 32'(score), 32'd403200);
        chk("sat40.total", 32'(total_lines), 32'd160);
      end
      if (i == 73) chk("sat73.score", 32'(score), 32'd1036800);
    end
    chk("sat74.score", 32'(score), 32'hFFFFF);
    chk("sat74.level", 32'(level), 32'd15);
    chk("sat74.total", 32'(total_lines), 32'd296);

    // Async reset at scan row 10 on a fully occupied board.
    build_board(20'hFFFFF);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("midscan.lines_pre", 32'(lines), 32'h003FF);
    RESET_N = 1'b0;
    #1;
    chk("arst.lines", 32'(lines), 32'h0);
    chk("arst.flags", 32'({CLEAR, BUSY, DONE}), 32'h0);
    chk("arst.stats", 32'({n_cleared, level, total_lines}), 32'h0);
    chk("arst.score", 32'(score), 32'h0);
    @(negedge CLK);
    @(negedge CLK); RESET_N = 1'b1;
    n_clr = 0; n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (CLEAR) n_clr++;
      if (DONE) n_done++;
    end
    chk("post_rst.no_pulses", 32'(n_clr + n_done), 32'd0);

    run_op(0, 1'b0);
    check_op("full_clamp", 32'hFFFFF, 21, 23, 32'd4, 32'd1200, 32'd4, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
